// File: rtl/ceres_dma_initiator.sv
// ceres_dma_initiator
// Bus-initiator DMA that copies a contiguous run of cache lines from src to
// dst. Each line is a line-wide read followed by a full-strobe write on the
// SoC memory request/response interface.
//
// Optional feature macro: CERES_DMA_TIMEOUT_EN
//   When defined, a request waiting TIMEOUT_CYCLES cycles without a response
//   is dropped and the transfer ends with err_code_o = 3.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              single-cycle start pulse (honoured only when idle)
//   src_addr_i/dst_addr_i line-aligned byte addresses
//   len_i                number of lines to copy
//   abort_i              abort request, level-sampled while busy
//   busy_o               transfer in progress (RD/WR)
//   done_o               single-cycle completion pulse
//   err_o, err_code_o    sticky error flag and cause (1 misaligned, 2 abort, 3 timeout)
//   lines_done_o         lines completed in the current/last transfer
//   req_*                request channel (req_rw_o all-zero = read)
//   res_*                response channel
module ceres_dma_initiator #(
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           src_addr_i,
    input  logic [31:0]           dst_addr_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic [LEN_W-1:0]      lines_done_o,
    output logic                  req_valid_o,
    output logic [31:0]           req_addr_o,
    output logic [LINE_W-1:0]     req_data_o,
    output logic [LINE_W/8-1:0]   req_rw_o,
    input  logic                  res_valid_i,
    input  logic                  res_ready_i,
    input  logic [LINE_W-1:0]     res_data_i
);

    localparam int unsigned BYTES  = LINE_W / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam logic [31:0] STRIDE = 32'(BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    state_e              state_r, state_n;
    logic [31:0]         src_cur_r, src_n;
    logic [31:0]         dst_cur_r, dst_n;
    logic [LEN_W-1:0]    len_r, len_n;
    logic [LEN_W-1:0]    lines_r, lines_n;
    logic [LINE_W-1:0]   line_buf_r, buf_n;
    logic                req_valid_r, valid_n;
    logic [31:0]         req_addr_r, addr_n;
    logic [LINE_W-1:0]   req_data_r, data_n;
    logic [BYTES-1:0]    req_rw_r, rw_n;
    logic                err_r, err_n;
    logic [1:0]          err_code_r, code_n;
    logic                abort_pend_r, abort_n;
    logic                busy_r, done_r;
    logic                abort_seen_s;
    logic                misaligned_s;

`ifdef CERES_DMA_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]     to_cnt_r, to_n;
`else
    // The timeout length has no effect without the timeout feature.
    if (TIMEOUT_CYCLES == 0) begin : g_unused_timeout_cfg
    end
`endif

    assign misaligned_s = (|src_addr_i[OFF_W-1:0]) | (|dst_addr_i[OFF_W-1:0]);

    // Next-state and next-register computation for the copy sequencer.
    always_comb begin
        state_n      = state_r;
        src_n        = src_cur_r;
        dst_n        = dst_cur_r;
        len_n        = len_r;
        lines_n      = lines_r;
        buf_n        = line_buf_r;
        valid_n      = req_valid_r;
        addr_n       = req_addr_r;
        data_n       = req_data_r;
        rw_n         = req_rw_r;
        err_n        = err_r;
        code_n       = err_code_r;
        abort_n      = abort_pend_r;
        abort_seen_s = 1'b0;
`ifdef CERES_DMA_TIMEOUT_EN
        to_n         = to_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    src_n   = src_addr_i;
                    dst_n   = dst_addr_i;
                    len_n   = len_i;
                    lines_n = {LEN_W{1'b0}};
                    err_n   = 1'b0;
                    code_n  = 2'd0;
                    abort_n = 1'b0;
                    if (misaligned_s) begin
                        state_n = ST_FIN;
                        err_n   = 1'b1;
                        code_n  = 2'd1;
                    end else if (len_i == {LEN_W{1'b0}}) begin
                        state_n = ST_FIN;
                    end else begin
                        state_n = ST_RD;
                    end
                end else begin
                    abort_n = 1'b0;
                end
            end
            ST_RD, ST_WR: begin
                // Abort is remembered so an in-flight request still completes.
                abort_seen_s = abort_i | abort_pend_r;
                abort_n      = abort_seen_s;
                if (req_valid_r) begin
                    if (res_valid_i) begin
                        valid_n = 1'b0;
`ifdef CERES_DMA_TIMEOUT_EN
                        to_n    = {TO_W{1'b0}};
`endif
                        if (state_r == ST_RD) begin
                            buf_n = res_data_i;
                            if (abort_seen_s) begin
                                state_n = ST_FIN;
                                err_n   = 1'b1;
                                code_n  = 2'd2;
                            end else begin
                                state_n = ST_WR;
                            end
                        end else begin
                            lines_n = lines_r + LEN_W'(1);
                            src_n   = src_cur_r + STRIDE;
                            dst_n   = dst_cur_r + STRIDE;
                            if (abort_seen_s) begin
                                state_n = ST_FIN;
                                err_n   = 1'b1;
                                code_n  = 2'd2;
                            end else if (lines_n == len_r) begin
                                state_n = ST_FIN;
                            end else begin
                                state_n = ST_RD;
                            end
                        end
                    end else begin
`ifdef CERES_DMA_TIMEOUT_EN
                        if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            valid_n = 1'b0;
                            to_n    = {TO_W{1'b0}};
                            state_n = ST_FIN;
                            err_n   = 1'b1;
                            code_n  = 2'd3;
                        end else begin
                            to_n = to_cnt_r + TO_W'(1);
                        end
`else
                        // Hold the request until the responder answers.
                        valid_n = 1'b1;
`endif
                    end
                end else if (abort_seen_s) begin
                    // Nothing in flight: stop before raising the next request.
                    state_n = ST_FIN;
                    err_n   = 1'b1;
                    code_n  = 2'd2;
                end else if (res_ready_i) begin
                    valid_n = 1'b1;
                    if (state_r == ST_RD) begin
                        addr_n = src_cur_r;
                        data_n = {LINE_W{1'b0}};
                        rw_n   = {BYTES{1'b0}};
                    end else begin
                        addr_n = dst_cur_r;
                        data_n = line_buf_r;
                        rw_n   = {BYTES{1'b1}};
                    end
                end else begin
                    valid_n = 1'b0;
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
                abort_n = 1'b0;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; request drops asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            src_cur_r    <= 32'h0000_0000;
            dst_cur_r    <= 32'h0000_0000;
            len_r        <= {LEN_W{1'b0}};
            lines_r      <= {LEN_W{1'b0}};
            line_buf_r   <= {LINE_W{1'b0}};
            req_valid_r  <= 1'b0;
            req_addr_r   <= 32'h0000_0000;
            req_data_r   <= {LINE_W{1'b0}};
            req_rw_r     <= {BYTES{1'b0}};
            err_r        <= 1'b0;
            err_code_r   <= 2'd0;
            abort_pend_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            src_cur_r    <= src_n;
            dst_cur_r    <= dst_n;
            len_r        <= len_n;
            lines_r      <= lines_n;
            line_buf_r   <= buf_n;
            req_valid_r  <= valid_n;
            req_addr_r   <= addr_n;
            req_data_r   <= data_n;
            req_rw_r     <= rw_n;
            err_r        <= err_n;
            err_code_r   <= code_n;
            abort_pend_r <= abort_n;
            busy_r       <= (state_n == ST_RD) || (state_n == ST_WR);
            done_r       <= (state_n == ST_FIN);
        end
    end

`ifdef CERES_DMA_TIMEOUT_EN
    // Wait counter for the in-flight request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_n;
        end
    end
`endif

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign err_code_o   = err_code_r;
    assign lines_done_o = lines_r;
    assign req_valid_o  = req_valid_r;
    assign req_addr_o   = req_addr_r;
    assign req_data_o   = req_data_r;
    assign req_rw_o     = req_rw_r;

endmodule

// File: tb/tb_ceres_dma_initiator.sv
// Self-checking bench for ceres_dma_initiator: table of directed transfers,
// randomized transfers checked against a line-level reference model, and
// hand-written reset / timeout sequences.
module tb_ceres_dma_initiator;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [31:0]   src_addr_i;
    logic [31:0]   dst_addr_i;
    logic [15:0]   len_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic [15:0]   lines_done_o;
    logic          req_valid_o;
    logic [31:0]   req_addr_o;
    logic [127:0]  req_data_o;
    logic [15:0]   req_rw_o;
    logic          res_valid_i;
    logic          res_ready_i;
    logic [127:0]  res_data_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ceres_dma_initiator #(.LINE_W(128), .LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .lines_done_o(lines_done_o),
        .req_valid_o(req_valid_o), .req_addr_o(req_addr_o),
        .req_data_o(req_data_o), .req_rw_o(req_rw_o),
        .res_valid_i(res_valid_i), .res_ready_i(res_ready_i),
        .res_data_i(res_data_i)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [15:0]  rw;
        logic [127:0] data;
    } tx_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          lat;
        int          abort_tx;
        int          hold;
        int          exp_code;
        int          exp_lines;
    } vec_t;

    tx_t  log_q[$];
    vec_t tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents of the source region: a fixed function of the address.
    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a ^ 32'h1357_9BDF, ~a, a + 32'h0F0F_0F0F, a ^ 32'hDEAD_BEEF};
    endfunction

    // Line-level reference: outcome of a transfer from the block's rules.
    task automatic model(input logic [31:0] src, input logic [31:0] dst, input int len,
                         input int abort_tx, output int code, output int lines, output int ntx);
        if (src[3:0] != 4'd0 || dst[3:0] != 4'd0) begin
            code = 1; lines = 0; ntx = 0;
        end else if (len == 0) begin
            code = 0; lines = 0; ntx = 0;
        end else if (abort_tx >= 0 && abort_tx < 2 * len) begin
            ntx = abort_tx + 1; lines = ntx / 2; code = 2;
        end else begin
            ntx = 2 * len; lines = len; code = 0;
        end
    endtask

    task automatic run(input string nm, input logic [31:0] src, input logic [31:0] dst,
                       input int len, input int lat, input int abort_tx, input int hold,
                       input int exp_code, input int exp_lines);
        int code_m, lines_m, ntx_m, done_exp, done_cnt, done_at, viol, wait_cnt, last_cmp;
        bit in_flight;
        logic [31:0]  l_addr, e_addr, line_a;
        logic [15:0]  l_rw;
        logic [127:0] l_data;
        model(src, dst, len, abort_tx, code_m, lines_m, ntx_m);
        done_exp = (ntx_m == 0) ? 0 : ntx_m * (lat + 2) + hold;
        done_cnt = 0; done_at = -1; viol = 0; wait_cnt = 0; last_cmp = -10; in_flight = 1'b0;
        l_addr = 32'h0; l_rw = 16'h0; l_data = 128'h0;
        log_q.delete();
        @(negedge clk_i);
        src_addr_i = src; dst_addr_i = dst; len_i = 16'(len); start_i = 1'b1;
        res_ready_i = (hold == 0);
        for (int c = 0; c < done_exp + 40; c++) begin
            @(negedge clk_i);
            start_i = (done_exp >= 4 && c == 2);
            if (start_i) begin
                src_addr_i = 32'h0000_1230; len_i = 16'd7;
            end
            res_ready_i = (c >= hold);
            if (c == 0) chk({nm, " err_o_at_start"}, 128'(err_o), 128'(exp_code == 1));
            if (busy_o !== (c < done_exp)) viol++;
            if (done_o) begin
                done_cnt++; done_at = c;
            end
            if (req_valid_o) begin
                if (abort_tx >= 0 && log_q.size() == abort_tx) abort_i = 1'b1;
                if (!in_flight) begin
                    if (c == last_cmp + 1) viol++;
                    in_flight = 1'b1; wait_cnt = 0;
                    l_addr = req_addr_o; l_rw = req_rw_o; l_data = req_data_o;
                end else if (req_addr_o !== l_addr || req_rw_o !== l_rw || req_data_o !== l_data) begin
                    viol++;
                end
                if (wait_cnt == lat) begin
                    res_valid_i = 1'b1;
                    res_data_i  = pat(req_addr_o);
                    log_q.push_back('{req_addr_o, req_rw_o, req_data_o});
                    in_flight = 1'b0; last_cmp = c;
                end else begin
                    res_valid_i = 1'b0; wait_cnt++;
                end
            end else begin
                if (in_flight) viol++;
                res_valid_i = 1'b0;
            end
            if (done_cnt > 0 && c >= done_at + 3) break;
        end
        start_i = 1'b0; abort_i = 1'b0; res_valid_i = 1'b0; res_ready_i = 1'b1;
        chk({nm, " done_pulses"}, 128'(done_cnt), 128'(1));
        chk({nm, " done_cycle"}, 128'(done_at), 128'(done_exp));
        chk({nm, " err_code"}, 128'(err_code_o), 128'(exp_code));
        chk({nm, " err_o"}, 128'(err_o), 128'(exp_code != 0));
        chk({nm, " lines_done"}, 128'(lines_done_o), 128'(exp_lines));
        chk({nm, " tx_count"}, 128'(log_q.size()), 128'(ntx_m));
        for (int i = 0; i < log_q.size() && i < ntx_m; i++) begin
            line_a = 32'(16 * (i / 2));
            e_addr = (i % 2 == 0) ? src + line_a : dst + line_a;
            chk($sformatf("%s tx%0d_addr_rw", nm, i), {80'h0, log_q[i].addr, log_q[i].rw},
                {80'h0, e_addr, (i % 2 == 0) ? 16'h0000 : 16'hFFFF});
            if (i % 2 == 1)
                chk($sformatf("%s tx%0d_wdata", nm, i), log_q[i].data, pat(src + line_a));
        end
        chk({nm, " protocol"}, 128'(viol), 128'(0));
    endtask

    initial begin
        int rc, rl, rn, rlen, rlat, rab, rhold, hi, dc;
        logic [31:0] rsrc, rdst;
        rst_ni = 1'b0; start_i = 1'b0; src_addr_i = 32'h0; dst_addr_i = 32'h0;
        len_i = 16'h0; abort_i = 1'b0; res_valid_i = 1'b0; res_ready_i = 1'b1;
        res_data_i = 128'h0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        chk("rst req_valid", 128'(req_valid_o), 128'(0));
        chk("rst busy", 128'(busy_o), 128'(0));
        chk("rst done", 128'(done_o), 128'(0));
        chk("rst err", 128'({err_o, err_code_o}), 128'(0));
        chk("rst lines", 128'(lines_done_o), 128'(0));
        chk("rst req_fields", {req_addr_o, req_rw_o, 80'h0} | req_data_o, 128'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        tbl[0] = '{32'h8000_0000, 32'h8000_1000, 4, 16, -1, 0, 0, 4};
        tbl[1] = '{32'h8000_0000, 32'h8000_1000, 0, 0, -1, 0, 0, 0};
        tbl[2] = '{32'h8000_0004, 32'h8000_1000, 3, 0, -1, 0, 1, 0};
        tbl[3] = '{32'h8000_0000, 32'h8000_2000, 8, 3, 2, 0, 2, 1};
        tbl[4] = '{32'hFFFF_FFF0, 32'h0000_1000, 2, 0, -1, 0, 0, 2};
        tbl[5] = '{32'h8000_0100, 32'h8000_0200, 1, 2, -1, 5, 0, 1};
        tbl[6] = '{32'h8000_0100, 32'h8000_0208, 2, 0, -1, 0, 1, 0};
        for (int i = 0; i < 7; i++)
            run($sformatf("vec%0d", i), tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].lat,
                tbl[i].abort_tx, tbl[i].hold, tbl[i].exp_code, tbl[i].exp_lines);

        for (int i = 0; i < 12; i++) begin
            rsrc = $urandom & 32'hFFFF_FFF0;
            rdst = $urandom & 32'hFFFF_FFF0;
            if ($urandom_range(0, 4) == 0) rsrc = rsrc | 32'($urandom_range(1, 15));
            rlen  = $urandom_range(0, 5);
            rlat  = $urandom_range(0, 3);
            rhold = $urandom_range(0, 2);
            rab   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * rlen) : -1;
            model(rsrc, rdst, rlen, rab, rc, rl, rn);
            run($sformatf("rnd%0d", i), rsrc, rdst, rlen, rlat, rab, rhold, rc, rl);
        end

        // Reset in the middle of a waiting request.
        @(negedge clk_i);
        src_addr_i = 32'h8000_0000; dst_addr_i = 32'h8000_1000; len_i = 16'd3; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        hi = 0;
        for (int c = 0; c < 10 && !req_valid_o; c++) @(negedge clk_i);
        chk("midrst valid_before", 128'(req_valid_o), 128'(1));
        rst_ni = 1'b0;
        #1;
        chk("midrst valid_async", 128'(req_valid_o), 128'(0));
        chk("midrst busy", 128'(busy_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (req_valid_o || busy_o) hi++;
        end
        chk("midrst stays_idle", 128'(hi), 128'(0));

`ifdef CERES_DMA_TIMEOUT_EN
        // Responder never answers: request must give up after 8 waiting cycles.
        hi = 0; dc = 0;
        res_valid_i = 1'b0;
        @(negedge clk_i);
        src_addr_i = 32'h8000_0000; dst_addr_i = 32'h8000_1000; len_i = 16'd1; start_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (req_valid_o) hi++;
            if (done_o) dc++;
        end
        chk("timeout valid_cycles", 128'(hi), 128'(8));
        chk("timeout err_code", 128'(err_code_o), 128'(3));
        chk("timeout done", 128'(dc), 128'(1));
        chk("timeout err_o", 128'(err_o), 128'(1));
`else
        dc = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
